// File: rtl/qc_shift_scheduler.sv
// qc_shift_scheduler: runs one QC-LDPC base-matrix row through an external LAT-stage
// right-rotate shifter, carrying valid/col/last/null tags alongside the shifter latency.
// Define SHIFT_SCHED_NULL_EN to enable null table entries (zeroed blocks, res_null flag).
module qc_shift_scheduler #(
    parameter int MAXZ = 81,
    parameter int NB   = 24,
    parameter int MB   = 12
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(MB*NB)-1:0] cfg_addr,
    input  logic [$clog2(MAXZ):0]    cfg_data,
    input  logic                     start,
    input  logic [$clog2(MB)-1:0]    row_idx,
    output logic                     busy,
    output logic                     done,
    input  logic                     blk_valid,
    output logic                     blk_ready,
    input  logic [MAXZ-1:0]          blk_data,
    output logic [MAXZ-1:0]          sh_data,
    output logic [$clog2(MAXZ)-1:0]  sh_shift,
    input  logic [MAXZ-1:0]          sh_result,
    output logic                     res_valid,
    output logic [MAXZ-1:0]          res_data,
    output logic [$clog2(NB)-1:0]    res_col,
    output logic                     res_last,
    output logic                     res_null
);
    localparam int SW  = $clog2(MAXZ);
    localparam int LAT = SW;
    localparam int AW  = $clog2(MB*NB);
    localparam int RW  = $clog2(MB);
    localparam int CW  = $clog2(NB);
`ifdef SHIFT_SCHED_NULL_EN
    localparam int EW  = SW + 1;
`else
    localparam int EW  = SW;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic          v;
        logic          last;
        logic          nul;
        logic [CW-1:0] col;
    } tag_t;

    state_t        state_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [SW-1:0] cnt_q;
    logic [EW-1:0] tbl_q [MB*NB];
    tag_t          tag_q [LAT];

    logic          accept;
    logic          col_last;
    logic          wr_en;
    logic          ent_null;
    logic [SW-1:0] ent_shift;
    logic [SW-1:0] wr_shift;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] entry;
    logic [AW-1:0] rd_addr;
    tag_t          tag_in;
    tag_t          tail;
    logic          unused_bits;

    // Table lookup for the current column, write-side shift reduction and output steering.
    always_comb begin
        accept    = state_q == RUN && blk_valid;
        col_last  = col_q == CW'(NB - 1);
        rd_addr   = AW'(row_q) * AW'(NB) + AW'(col_q);
        entry     = tbl_q[rd_addr];
        ent_shift = entry[SW-1:0];
        wr_en     = cfg_we && state_q == IDLE && {1'b0, cfg_addr} < (AW+1)'(MB*NB);
        wr_shift  = {1'b0, cfg_data[SW-1:0]} >= (SW+1)'(MAXZ) ? cfg_data[SW-1:0] - SW'(MAXZ)
                                                                : cfg_data[SW-1:0];
        tail      = tag_q[LAT-1];
`ifdef SHIFT_SCHED_NULL_EN
        ent_null    = entry[SW];
        wr_entry    = {cfg_data[SW], wr_shift};
        res_null    = tail.nul;
        unused_bits = 1'b0;
`else
        ent_null    = 1'b0;
        wr_entry    = wr_shift;
        res_null    = 1'b0;
        unused_bits = cfg_data[SW] ^ tail.nul;
`endif
        tag_in.v    = accept;
        tag_in.last = accept && col_last;
        tag_in.nul  = accept && ent_null;
        tag_in.col  = accept ? col_q : '0;
        busy        = state_q != IDLE;
        blk_ready   = state_q == RUN;
        sh_data     = accept && !ent_null ? blk_data : '0;
        sh_shift    = accept && !ent_null ? ent_shift : '0;
        res_valid   = tail.v;
        res_data    = tail.v ? sh_result : '0;
        res_col     = tail.col;
        res_last    = tail.last;
        done        = state_q == DRAIN && tail.v && tail.last;
    end

    // Shift table storage; deliberately not reset so contents survive rst.
    always_ff @(posedge CLK) begin
        if (wr_en) tbl_q[cfg_addr] <= wr_entry;
    end

    // Job sequencing: IDLE accepts start, RUN consumes NB blocks, DRAIN waits out the shifter.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && {1'b0, row_idx} < (RW+1)'(MB)) begin
                        row_q   <= row_idx;
                        col_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        col_q <= col_last ? '0 : col_q + CW'(1);
                        if (col_last) begin
                            cnt_q   <= '0;
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    cnt_q <= cnt_q + SW'(1);
                    if (cnt_q == SW'(LAT - 1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag pipeline matching the shifter latency; cleared on reset so no stale result escapes.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end
endmodule

// File: tb/tb_qc_shift_scheduler.sv
// tb_qc_shift_scheduler: randomized and directed checks of qc_shift_scheduler against a
// cycle-timeline reference model, with a behavioural pipelined rotator standing in for the shifter.
module tb_qc_shift_scheduler;
    localparam int MAXZ = 81;
    localparam int NB   = 24;
    localparam int MB   = 12;
    localparam int SW   = 7;
    localparam int LAT  = 7;
    localparam int AW   = 9;
    localparam int RW   = 4;
    localparam int CW   = 5;
`ifdef SHIFT_SCHED_NULL_EN
    localparam bit NULL_EN = 1'b1;
`else
    localparam bit NULL_EN = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_we = 1'b0;
    logic [AW-1:0]   cfg_addr = '0;
    logic [SW:0]     cfg_data = '0;
    logic            start = 1'b0;
    logic [RW-1:0]   row_idx = '0;
    logic            blk_valid = 1'b0;
    logic [MAXZ-1:0] blk_data = '0;
    logic            busy, done, blk_ready, res_valid, res_last, res_null;
    logic [MAXZ-1:0] sh_data, sh_result, res_data;
    logic [SW-1:0]   sh_shift;
    logic [CW-1:0]   res_col;
    logic            sh_rst_n;
    logic [MAXZ-1:0] pipe [LAT];

    qc_shift_scheduler #(.MAXZ(MAXZ), .NB(NB), .MB(MB)) dut (
        .CLK(CLK), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .row_idx(row_idx), .busy(busy), .done(done),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .sh_data(sh_data), .sh_shift(sh_shift), .sh_result(sh_result),
        .res_valid(res_valid), .res_data(res_data), .res_col(res_col),
        .res_last(res_last), .res_null(res_null)
    );

    always #5 CLK = ~CLK;

    function automatic logic [MAXZ-1:0] rotr(input logic [MAXZ-1:0] x, input int s);
        logic [MAXZ-1:0] r;
        for (int i = 0; i < MAXZ; i++) r[i] = x[(i + s) % MAXZ];
        return r;
    endfunction

    assign sh_rst_n  = !rst;
    assign sh_result = pipe[LAT-1];

    always @(posedge CLK or negedge sh_rst_n) begin
        if (!sh_rst_n) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= rotr(sh_data, int'(sh_shift));
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    typedef struct {
        int              due;
        logic [MAXZ-1:0] data;
        int              col;
        bit              last;
        bit              nul;
    } exp_t;

    int   m_shift [MB*NB];
    bit   m_null  [MB*NB];
    exp_t q[$];
    bit   job_on = 1'b0;
    int   m_row = 0, m_ncol = 0, done_at = -1;
    int   cyc = 0, start_cyc = 0, done_cyc = 0;
    int   checks = 0, failures = 0;
    bit   lit_one = 1'b0, lit_null = 1'b0, done_seen = 1'b0;

    task automatic chk(input string name, input logic [MAXZ-1:0] act, input logic [MAXZ-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        exp_t            e, ne;
        bit              e_v, e_done, e_ready, acc, nl;
        int              a, s;
        logic [MAXZ-1:0] e_sd;
        int              e_ss;
        if (rst) begin
            q.delete();
            job_on  = 1'b0;
            done_at = -1;
        end
        e_ready = job_on && m_ncol < NB;
        e_done  = job_on && cyc == done_at;
        e_v     = q.size() > 0 && q[0].due == cyc;
        e.due = 0; e.data = '0; e.col = 0; e.last = 1'b0; e.nul = 1'b0;
        if (e_v) e = q[0];
        acc  = e_ready && blk_valid && !rst;
        a    = e_ready ? m_row * NB + m_ncol : 0;
        nl   = NULL_EN && m_null[a];
        e_sd = acc && !nl ? blk_data : '0;
        e_ss = acc && !nl ? m_shift[a] : 0;
        chk("busy", MAXZ'(busy), MAXZ'(job_on));
        chk("blk_ready", MAXZ'(blk_ready), MAXZ'(e_ready));
        chk("done", MAXZ'(done), MAXZ'(e_done));
        chk("sh_data", sh_data, e_sd);
        chk("sh_shift", MAXZ'(sh_shift), MAXZ'(e_ss));
        chk("res_valid", MAXZ'(res_valid), MAXZ'(e_v));
        chk("res_data", res_data, e.data);
        chk("res_col", MAXZ'(res_col), MAXZ'(e.col));
        chk("res_last", MAXZ'(res_last), MAXZ'(e.last));
        chk("res_null", MAXZ'(res_null), MAXZ'(e.nul));
        if (e_v && lit_one) chk("lit_one", res_data, MAXZ'(1));
        if (e_v && lit_null) begin
            chk("lit_null_data", res_data, (NULL_EN && e.col == 5) ? MAXZ'(0) : {MAXZ{1'b1}});
            chk("lit_null_flag", MAXZ'(res_null), MAXZ'(NULL_EN && e.col == 5));
        end
        if (done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
        if (!rst) begin
            if (e_v) void'(q.pop_front());
            if (e_done) begin
                job_on = 1'b0;
            end else if (!job_on) begin
                if (cfg_we && int'(cfg_addr) < MB * NB) begin
                    s = int'(cfg_data[SW-1:0]);
                    m_shift[cfg_addr] = s >= MAXZ ? s - MAXZ : s;
                    m_null[cfg_addr]  = cfg_data[SW];
                end
                if (start && int'(row_idx) < MB) begin
                    job_on    = 1'b1;
                    m_row     = int'(row_idx);
                    m_ncol    = 0;
                    done_at   = -1;
                    start_cyc = cyc;
                end
            end else if (acc) begin
                ne.due  = cyc + LAT;
                ne.col  = m_ncol;
                ne.last = m_ncol == NB - 1;
                ne.nul  = nl;
                ne.data = nl ? '0 : rotr(blk_data, m_shift[a]);
                q.push_back(ne);
                m_ncol++;
                if (m_ncol == NB) done_at = cyc + LAT;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_addr = AW'(addr);
        cfg_data = (SW+1)'(data);
        tick();
        cfg_we   = 1'b0;
    endtask

    function automatic logic [MAXZ-1:0] rnd_blk();
        return MAXZ'({$urandom(), $urandom(), $urandom()});
    endfunction

    // dmode: 0 one-hot by column, 1 all ones, 2 bit 9, 3 random; vmode: 0 gapless, 1 toggle, 2 random.
    task automatic run_job(input int row, input int dmode, input int vmode, input int inject_at,
                           input int abort_at, input int co_addr, input int co_data);
        int n = 0, guard = 0;
        bit v;
        start   = 1'b1;
        row_idx = RW'(row);
        if (co_addr >= 0) begin
            cfg_we   = 1'b1;
            cfg_addr = AW'(co_addr);
            cfg_data = (SW+1)'(co_data);
        end
        tick();
        start     = 1'b0;
        cfg_we    = 1'b0;
        done_seen = 1'b0;
        while (n < NB && guard < 400) begin
            guard++;
            v = vmode == 0 ? 1'b1 : vmode == 1 ? (guard % 2 == 1) : 1'($urandom_range(0, 1));
            blk_valid = v;
            blk_data  = dmode == 0 ? MAXZ'(1) << n : dmode == 1 ? {MAXZ{1'b1}} :
                        dmode == 2 ? MAXZ'(1) << 9 : rnd_blk();
            cfg_we = n == inject_at;
            start  = n == inject_at;
            if (n == inject_at) begin
                cfg_addr = AW'(row * NB + 20);
                cfg_data = (SW+1)'(5);
                row_idx  = RW'((row + 1) % MB);
            end
            if (n == abort_at) begin
                blk_valid = 1'b0;
                cfg_we    = 1'b0;
                start     = 1'b0;
                rst       = 1'b1;
                tick();
                rst = 1'b0;
                tick();
                chk("rst_busy", MAXZ'(busy), MAXZ'(0));
                chk("rst_res_valid", MAXZ'(res_valid), MAXZ'(0));
                chk("rst_no_done", MAXZ'(done_seen), MAXZ'(0));
                return;
            end
            if (v && blk_ready) n++;
            tick();
        end
        blk_valid = 1'b0;
        cfg_we    = 1'b0;
        start     = 1'b0;
        guard     = 0;
        while (!done_seen && guard < 40) begin
            tick();
            guard++;
        end
        checks++;
        if (!done_seen) begin
            failures++;
            $display("FAIL done_timeout row=%0d actual=no_done required=done", row);
        end
        tick();
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < MB * NB; i++) cfg_write(i, int'($urandom_range(0, 255)));
        cfg_write(300, 3);
        cfg_write(511, 200);
        for (int c = 0; c < NB; c++) cfg_write(c, c);
        lit_one = 1'b1;
        run_job(0, 0, 0, -1, -1, -1, 0);
        lit_one = 1'b0;
        chk("done_cycle", MAXZ'(done_cyc - start_cyc), MAXZ'(NB + LAT));
        for (int c = 0; c < NB; c++) cfg_write(NB + c, c == 5 ? 128 + 10 : 0);
        lit_null = 1'b1;
        run_job(1, 1, 0, -1, -1, -1, 0);
        lit_null = 1'b0;
        for (int c = 0; c < NB; c++) cfg_write(2 * NB + c, c == 0 ? 90 : 9);
        lit_one = 1'b1;
        run_job(2, 2, 0, -1, -1, -1, 0);
        lit_one = 1'b0;
        run_job(4, 3, 1, -1, -1, -1, 0);
        run_job(5, 3, 0, 8, -1, -1, 0);
        start   = 1'b1;
        row_idx = RW'(12);
        tick();
        start = 1'b0;
        repeat (3) tick();
        run_job(6, 3, 2, -1, -1, 6 * NB + 3, 77);
        run_job(7, 3, 0, -1, 10, -1, 0);
        run_job(7, 3, 0, -1, -1, -1, 0);
        run_job(5, 3, 0, -1, -1, -1, 0);
        blk_valid = 1'b1;
        blk_data  = {MAXZ{1'b1}};
        repeat (3) tick();
        blk_valid = 1'b0;
        for (int k = 0; k < 6; k++) run_job(int'($urandom_range(0, MB - 1)), 3, 2, -1, -1, -1, 0);
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
